// File: rtl/cdc1_ctrl.sv
`default_nettype none
// =====================================================================
// cdc1_ctrl : precharge/evaluate sequencer and discharge-time digitiser
//             for one cdc1 cell. Option macro: CDC1_CTRL_AVG_EN
// Rev 1.0
// =====================================================================
module cdc1_ctrl #(
  parameter int CNT_W   = 10,
  parameter int PRE_CYC = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  output logic             BUSY,
  output logic             I1,
  output logic             I2,
  input  logic             VO_IN,
  output logic [CNT_W-1:0] RES,
  output logic             TMO,
  output logic             RES_VLD,
  input  logic             RES_RDY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRECH = 3'd1,
    S_GAP   = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int              PW         = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;
  localparam logic [PW-1:0]   c_pre_last = PW'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           r_state, w_next;
  logic             r_vo_m, r_vo_s;
  logic [PW-1:0]    r_pcnt;
  logic [CNT_W-1:0] r_cnt, w_res_val;
  logic             r_i1, r_i2, r_busy, r_res_vld, r_tmo;
  logic [CNT_W-1:0] r_res;
  logic             w_tmo_hit, w_eval_end, w_last_pass, w_capture;

  // Reset to 1 so a released cell does not look discharged.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_vo_m <= 1'b1;
      r_vo_s <= 1'b1;
    end else begin
      r_vo_m <= VO_IN;
      r_vo_s <= r_vo_m;
    end
  end

  assign w_tmo_hit  = (r_cnt == c_cnt_max);
  assign w_eval_end = w_tmo_hit || !r_vo_s;
  assign w_capture  = (r_state == S_EVAL) && w_eval_end && (w_tmo_hit || w_last_pass);

`ifdef CDC1_CTRL_AVG_EN
  logic [1:0]       r_pass;
  logic [CNT_W+1:0] r_acc, w_acc_sum;

  assign w_acc_sum   = r_acc + {2'b00, r_cnt};
  assign w_last_pass = (r_pass == 2'd3);
  assign w_res_val   = w_acc_sum[CNT_W+1:2];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_pass <= '0;
      r_acc  <= '0;
    end else if (r_state == S_IDLE) begin
      r_pass <= '0;
      r_acc  <= '0;
    end else if ((r_state == S_EVAL) && w_eval_end) begin
      r_pass <= r_pass + 2'd1;
      r_acc  <= w_acc_sum;
    end
  end
`else
  assign w_last_pass = 1'b1;
  assign w_res_val   = r_cnt;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_next = S_PRECH;
      S_PRECH: if (r_pcnt == c_pre_last) w_next = S_GAP;
      S_GAP:   w_next = S_EVAL;
      S_EVAL:  if (w_eval_end) w_next = (w_tmo_hit || w_last_pass) ? S_DONE : S_PRECH;
      S_DONE:  if (r_res_vld && RES_RDY) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Gate drives are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= S_IDLE;
      r_i1      <= 1'b1;
      r_i2      <= 1'b0;
      r_busy    <= 1'b0;
      r_res_vld <= 1'b0;
      r_pcnt    <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_i1      <= (w_next != S_PRECH);
      r_i2      <= (w_next == S_EVAL);
      r_busy    <= (w_next != S_IDLE);
      r_res_vld <= (w_next == S_DONE);
      r_pcnt    <= (r_state == S_PRECH) ? r_pcnt + PW'(1) : '0;
      if ((w_next == S_EVAL) && (r_state != S_EVAL))
        r_cnt <= '0;
      else if ((r_state == S_EVAL) && r_vo_s && !w_tmo_hit)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_res <= '0;
      r_tmo <= 1'b0;
    end else if (w_capture) begin
      r_tmo <= w_tmo_hit;
      r_res <= w_tmo_hit ? c_cnt_max : w_res_val;
    end
  end

  assign I1      = r_i1;
  assign I2      = r_i2;
  assign BUSY    = r_busy;
  assign RES     = r_res;
  assign TMO     = r_tmo;
  assign RES_VLD = r_res_vld;

endmodule
`default_nettype wire

// File: tb/tb_cdc1_ctrl.sv
`default_nettype none
// =====================================================================
// tb_cdc1_ctrl : randomized scoreboard bench for cdc1_ctrl (single pass)
// Rev 1.0
// =====================================================================
module tb_cdc1_ctrl;

  localparam int CNT_W   = 10;
  localparam int PRE_CYC = 8;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RSTN, START, VO_IN, RES_RDY;
  logic             BUSY, I1, I2, TMO, RES_VLD;
  logic [CNT_W-1:0] RES;

  typedef struct {int res; int tmo;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  cdc1_ctrl #(.CNT_W(CNT_W), .PRE_CYC(PRE_CYC)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .BUSY(BUSY), .I1(I1), .I2(I2),
    .VO_IN(VO_IN), .RES(RES), .TMO(TMO), .RES_VLD(RES_VLD), .RES_RDY(RES_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: vo_s drops two cycles after VO_IN; the result is the number of
  // evaluate cycles before that, saturating into a timeout at the counter max.
  // mode 0: VO_IN falls d cycles into evaluate; 1: already low; 2: never falls.
  function automatic exp_t model(input int mode, input int d);
    int k;
    exp_t e;
    if (mode == 1)      k = 0;
    else if (mode == 2) k = MAXC;
    else                k = d + 2;
    if (k >= MAXC) begin e.res = MAXC; e.tmo = 1; end
    else begin e.res = k; e.tmo = 0; end
    return e;
  endfunction

  // Monitor: pops on each new result and enforces stability/non-overlap.
  initial begin
    bit   prev_vld = 0;
    exp_t cur;
    cur.res = 0; cur.tmo = 0;
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        prev_vld = 0;
      end else begin
        if (!I1 && I2) chk("gate_overlap", 1, 0);
        if (RES_VLD && !prev_vld) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("res", int'(RES), cur.res);
            chk("tmo", int'(TMO), cur.tmo);
            chk("i2_low_at_vld", int'(I2), 0);
          end
        end else if (RES_VLD) begin
          chk("res_stable", int'(RES), cur.res);
          chk("tmo_stable", int'(TMO), cur.tmo);
        end
        prev_vld = RES_VLD;
      end
    end
  end

  task automatic convert(input int mode, input int d, input int hold);
    int n;
    @(posedge CLK); #2;
    VO_IN = (mode == 1) ? 1'b0 : 1'b1;
    START = 1'b1;
    exp_q.push_back(model(mode, d));
    for (int c = 1; c <= PRE_CYC + 2; c++) begin
      @(posedge CLK); #2;
      START = 1'b0;
      @(negedge CLK);
      if (c <= PRE_CYC) begin
        chk("prech_i1", int'(I1), 0);
        chk("prech_busy", int'(BUSY), 1);
        chk("prech_i2", int'(I2), 0);
      end else if (c == PRE_CYC + 1) begin
        chk("gap_i1", int'(I1), 1);
        chk("gap_i2", int'(I2), 0);
      end else begin
        chk("eval_i2", int'(I2), 1);
        chk("eval_i1", int'(I1), 1);
      end
    end
    RES_RDY = (hold == 0);
    if (mode == 0) begin
      repeat (d) @(negedge CLK);
      VO_IN = 1'b0;
    end
    n = 0;
    while (!RES_VLD && n < 1200) begin
      @(negedge CLK);
      n++;
    end
    if (!RES_VLD) chk("result_wait_expired", n, -1);
    for (int h = 0; h < hold; h++) begin
      START = (h >= hold - 3);
      @(negedge CLK);
      chk("hold_busy", int'(BUSY), 1);
      chk("hold_vld", int'(RES_VLD), 1);
    end
    RES_RDY = 1'b1;
    @(negedge CLK);
    chk("idle_busy", int'(BUSY), 0);
    chk("idle_vld", int'(RES_VLD), 0);
    START = 1'b0;
    @(negedge CLK);
    chk("no_restart", int'(BUSY), 0);
    VO_IN = 1'b1;
  endtask

  initial begin
    int n, mode, d;
    RSTN = 1'b0; START = 1'b0; VO_IN = 1'b1; RES_RDY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_i1", int'(I1), 1);
    chk("rst_i2", int'(I2), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_vld", int'(RES_VLD), 0);
    chk("rst_res", int'(RES), 0);
    chk("rst_tmo", int'(TMO), 0);
    @(posedge CLK); #2 RSTN = 1'b1;

    convert(0, 20, 0);   // RES = 22
    convert(0, 0, 0);    // RES = 2
    convert(1, 0, 0);    // already discharged -> 0
    convert(2, 0, 0);    // timeout
    convert(0, 37, 15);  // backpressure with ignored START
    for (int i = 0; i < 12; i++) begin
      mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      d    = $urandom_range(0, 60);
      convert(mode, d, $urandom_range(0, 4));
    end

    // Reset in the middle of evaluate: no result must follow.
    @(posedge CLK); #2 START = 1'b1;
    @(posedge CLK); #2 START = 1'b0;
    n = 0;
    while (!I2 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_eval", int'(I2), 1);
    repeat (5) @(posedge CLK);
    #3 RSTN = 1'b0;
    #1;
    chk("arst_i2", int'(I2), 0);
    chk("arst_i1", int'(I1), 1);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_vld", int'(RES_VLD), 0);
    @(posedge CLK); #2 RSTN = 1'b1;
    repeat (40) @(negedge CLK);
    chk("post_rst_vld", int'(RES_VLD), 0);
    chk("post_rst_busy", int'(BUSY), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
